servile_sram_bridge: RTL
========================

Name: servile_sram_bridge

Overview:
- Wishbone slave that sits directly downstream of the servile I/D arbiter's memory port (o_wb_mem_*).
- Serialises each 32-bit access into four byte cycles on an external 8-bit asynchronous SRAM.
- Timing is set by a programmable wait-state count.
- Returns assembled read data and a single-cycle ack to the arbiter.

Parameters:
- AW, 19, SRAM byte-address width (512 KiB); legal range 2..32.
- WAIT, 2, cycles each byte strobe is held active; must be >=1 (elaboration error otherwise).

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_wb_adr  in  32  byte address from arbiter; bits [1:0] ignored
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte enables
- i_wb_we  in  1  write when 1
- i_wb_stb  in  1  request
- o_wb_rdt  out  32  read data, valid while o_wb_ack=1
- o_wb_ack  out  1  single-cycle completion pulse
- o_sram_adr  out  AW  SRAM byte address
- o_sram_dout  out  8  SRAM write data
- i_sram_din  in  8  SRAM read data
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (async, takes effect immediately, including mid-access): o_wb_ack=0, o_wb_rdt=0, o_sram_ce_n=1, o_sram_oe_n=1, o_sram_we_n=1, o_sram_adr=0, o_sram_dout=0; FSM=IDLE. An aborted access never acks.
- FSM states: IDLE, STROBE, RECOVER, ACK.
- IDLE
  - On i_wb_stb=1: latch adr[AW-1:2], dat, sel, we; lane=0; wait counter=WAIT-1; go to STROBE.
  - Otherwise stay. SRAM strobes are all high.
- STROBE
  - o_sram_adr={adr[AW-1:2], lane}; o_sram_ce_n=0.
  - Read: o_sram_oe_n=0.
  - Write: o_sram_we_n = !sel[lane]; o_sram_dout=dat[8*lane+7:8*lane].
  - Counter decrements each cycle. When it reaches 0 (after WAIT cycles): a read samples i_sram_din into rdt[8*lane+7:8*lane]; go to RECOVER.
- RECOVER
  - One cycle. oe_n=1 and we_n=1; ce_n, address and dout held.
  - If lane==3 go to ACK; else lane+1, counter=WAIT-1, go to STROBE.
- ACK
  - o_wb_ack=1 for exactly one cycle; o_wb_rdt holds the assembled word; ce_n=1; go to IDLE.
  - o_wb_rdt keeps its value afterwards; it is don't-care when ack=0.
- Byte order is little-endian: lane k maps to bits [8k+7:8k] at SRAM address base+k.
- Latency: stb sampled in IDLE at cycle 0 gives ack at cycle 4*(WAIT+1)+1. WAIT=2 gives ack at cycle 13.
- IDLE is re-entered the cycle after ack, so an stb still high in that cycle starts a new access. The arbiter-side master drops stb the cycle after ack, so there is no spurious repeat.
- i_wb_stb, adr, dat, sel and we changes after capture are ignored; the latched access always completes and acks.
- Write with sel=0 (macro off): four byte phases, we_n stays high throughout, ack still issued.
- Address wrap: adr bits above AW-1 are discarded; no error signalled.

Optional Feature:
- Macro: SERVILE_SRAM_SKIP_EN.
- Defined:
  - Writes skip lanes whose sel bit is 0; FSM advances directly to the next selected lane with no STROBE or RECOVER cycles for skipped lanes.
  - Write with sel=0 goes IDLE->ACK, so ack arrives at cycle 1.
  - Write latency = 1 + popcount(sel)*(WAIT+1) + 0.
  - Reads are unaffected and always fetch all four lanes.
- Undefined: every access runs all four lanes as described in Behaviour.

Test Plan:
- Reset: assert i_rst mid-STROBE of a write -> ce_n/oe_n/we_n go to 1 in the same cycle, no ack; after release, next access is serviced normally.
- Read, WAIT=2, adr=0x0000_1004, SRAM holds 0x11,0x22,0x33,0x44 at 0x1004..0x1007 -> SRAM addresses 0x1004..0x1007 in order, oe_n low 2 cycles each; ack at cycle 13 with rdt=0x4433_2211.
- Write, adr=0x20, dat=0xA1B2C3D4, sel=0b0101 (macro off) -> we_n pulses low only for lanes 0 and 2 (data 0xD4 at 0x20, 0xB2 at 0x22); bytes 0x21/0x23 unchanged; ack at cycle 13.
- Same write with SERVILE_SRAM_SKIP_EN -> only addresses 0x20 and 0x22 driven; ack at cycle 7. sel=0 -> ack at cycle 1, no SRAM activity.
- Back-to-back: stb held high across ack, second access at adr=0x40 -> second access starts in the cycle after ack and acks 4*(WAIT+1)+1 cycles after that start; stb dropped mid-access -> ack still issued.
- WAIT=1, AW=4, adr=0x0000_00F8 -> SRAM addresses 0x8..0xB (upper bits dropped); ack at cycle 9.

Source files
------------

// File: rtl/servile_sram_bridge.sv
// Wishbone slave that splits each 32-bit access into four byte cycles on an 8-bit async SRAM.
// Optional SERVILE_SRAM_SKIP_EN: writes skip byte lanes whose select bit is clear.
module servile_sram_bridge #(
    parameter int AW   = 19,
    parameter int WAIT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [31:0]   i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [AW-1:0] o_sram_adr,
    output logic [7:0]    o_sram_dout,
    input  logic [7:0]    i_sram_din,
    output logic          o_sram_ce_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_we_n
);
    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2,
        ACK     = 2'd3
    } state_t;

    if (WAIT < 1) begin : g_bad_wait
        $error("servile_sram_bridge: WAIT must be >= 1");
    end
    if ((AW < 2) || (AW > 32)) begin : g_bad_aw
        $error("servile_sram_bridge: AW must be in 2..32");
    end

    state_t        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] sram_adr_q, sram_adr_d;
    logic [7:0]    dout_q, dout_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic [2:0]    pick_idle_s;
    logic [2:0]    pick_rec_s;
    logic          unused_s;

    assign unused_s = ^i_wb_adr;

`ifdef SERVILE_SRAM_SKIP_EN
    // Lowest lane >= start that carries data (any lane for reads); 4 means none left.
    function automatic logic [2:0] next_lane(input logic we, input logic [3:0] sel,
                                             input logic [2:0] start);
        logic [2:0] res;
        res = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if ((3'(k) >= start) && (sel[k] || !we)) begin
                res = 3'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_idle_s = next_lane(i_wb_we, i_wb_sel, 3'd0);
    assign pick_rec_s  = next_lane(we_q, sel_q, {1'b0, lane_q} + 3'd1);
`else
    assign pick_idle_s = 3'd0;
    assign pick_rec_s  = {1'b0, lane_q} + 3'd1;
`endif

    // Next-state logic; SRAM/Wishbone outputs are derived from the next state and registered.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdt_d   = rdt_q;
        case (state_q)
            IDLE: begin
                if (i_wb_stb) begin
                    base_d = i_wb_adr[AW-1:0];
                    dat_d  = i_wb_dat;
                    sel_d  = i_wb_sel;
                    we_d   = i_wb_we;
                    cnt_d  = CW'(WAIT - 1);
                    lane_d = pick_idle_s[1:0];
                    if (pick_idle_s[2]) begin
                        state_d = ACK;
                    end else begin
                        state_d = STROBE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdt_d[{lane_q, 3'b000} +: 8] = i_sram_din;
                    end else begin
                        rdt_d = rdt_q;
                    end
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RECOVER: begin
                if (pick_rec_s[2]) begin
                    state_d = ACK;
                end else begin
                    lane_d  = pick_rec_s[1:0];
                    cnt_d   = CW'(WAIT - 1);
                    state_d = STROBE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d  = (state_d == ACK);
        ce_n_d = !((state_d == STROBE) || (state_d == RECOVER));
        oe_n_d = !((state_d == STROBE) && !we_d);
        we_n_d = !((state_d == STROBE) && we_d && sel_d[lane_d]);
        // Address and write data only move when a strobe phase begins; recovery holds them.
        if (state_d == STROBE) begin
            sram_adr_d = ((base_d >> 2) << 2) | AW'(lane_d);
        end else begin
            sram_adr_d = sram_adr_q;
        end
        if ((state_d == STROBE) && we_d) begin
            dout_d = dat_d[{lane_d, 3'b000} +: 8];
        end else begin
            dout_d = dout_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            lane_q     <= 2'd0;
            cnt_q      <= '0;
            base_q     <= '0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            rdt_q      <= 32'd0;
            ack_q      <= 1'b0;
            sram_adr_q <= '0;
            dout_q     <= 8'd0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            sram_adr_q <= sram_adr_d;
            dout_q     <= dout_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign o_wb_rdt    = rdt_q;
    assign o_wb_ack    = ack_q;
    assign o_sram_adr  = sram_adr_q;
    assign o_sram_dout = dout_q;
    assign o_sram_ce_n = ce_n_q;
    assign o_sram_oe_n = oe_n_q;
    assign o_sram_we_n = we_n_q;
endmodule
